// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite layer compositor.
package sprite_pkg;

  localparam int SPR_COORD_W = 11;
  localparam int SPR_LOCAL_W = 12;
  localparam int SPR_PIX_W   = 10;
  localparam int SPR_ORG_W   = 9;
  localparam int SPR_SIZE_W  = 7;

  // One attribute slot: screen position, sheet origin, size in texels, flags.
  typedef struct packed {
    logic signed [SPR_COORD_W-1:0] x;
    logic signed [SPR_COORD_W-1:0] y;
    logic [SPR_ORG_W-1:0]          sx;
    logic [SPR_ORG_W-1:0]          sy;
    logic [SPR_SIZE_W-1:0]         w;
    logic [SPR_SIZE_W-1:0]         h;
    logic                          en;
    logic                          flip;
  } sprite_attr_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Per-slot coverage test: is (draw_x, draw_y) inside the scaled sprite, and
// which texel (tx, ty) of the sprite does it land on.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int SCALE_LOG2 = 1
) (
  input  sprite_attr_t           i_attr,
  input  logic [SPR_PIX_W-1:0]   i_draw_x,
  input  logic [SPR_PIX_W-1:0]   i_draw_y,
  output logic                   o_hit,
  output logic [SPR_SIZE_W-1:0]  o_tx,
  output logic [SPR_SIZE_W-1:0]  o_ty
);

  logic signed [SPR_LOCAL_W-1:0] w_lx;
  logic signed [SPR_LOCAL_W-1:0] w_ly;
  logic [SPR_LOCAL_W-1:0]        w_span_x;
  logic [SPR_LOCAL_W-1:0]        w_span_y;
  logic [SPR_SIZE_W-1:0]         w_tx_raw;

  // Local coordinates; 12 bits signed covers every 10b pixel minus 11b signed position.
  assign w_lx = $signed({2'b00, i_draw_x}) - $signed({i_attr.x[SPR_COORD_W-1], i_attr.x});
  assign w_ly = $signed({2'b00, i_draw_y}) - $signed({i_attr.y[SPR_COORD_W-1], i_attr.y});

  assign w_span_x = SPR_LOCAL_W'(i_attr.w) << SCALE_LOG2;
  assign w_span_y = SPR_LOCAL_W'(i_attr.h) << SCALE_LOG2;

  // Negative local coordinates fail via the sign bit, so the compares can be unsigned.
  assign o_hit = i_attr.en
               & ~w_lx[SPR_LOCAL_W-1] & ($unsigned(w_lx) < w_span_x)
               & ~w_ly[SPR_LOCAL_W-1] & ($unsigned(w_ly) < w_span_y);

  assign w_tx_raw = w_lx[SCALE_LOG2 +: SPR_SIZE_W];
  assign o_tx     = i_attr.flip ? (i_attr.w - 7'd1 - w_tx_raw) : w_tx_raw;
  assign o_ty     = w_ly[SCALE_LOG2 +: SPR_SIZE_W];

endmodule

// File: rtl/sprite_layer_compositor.sv
// Sprite layer: double-buffered attribute slots, priority select, sheet ROM
// addressing and ROM-aligned palette index output.
module sprite_layer_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SHEET_W     = 360,
  parameter int SHEET_H     = 264,
  parameter int ADDR_W      = 17,
  parameter int IDX_W       = 4,
  parameter int SCALE_LOG2  = 1,
  parameter int ROM_LAT     = 1,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = '0
) (
  input  logic                           i_vga_clk,
  input  logic                           i_reset,
  input  logic [SPR_PIX_W-1:0]           i_draw_x,
  input  logic [SPR_PIX_W-1:0]           i_draw_y,
  input  logic                           i_blank,
  input  logic                           i_frame_start,
  input  logic                           i_attr_we,
  input  logic [$clog2(NUM_SPRITES)-1:0] i_attr_sel,
  input  logic signed [SPR_COORD_W-1:0]  i_attr_x,
  input  logic signed [SPR_COORD_W-1:0]  i_attr_y,
  input  logic [SPR_ORG_W-1:0]           i_attr_sx,
  input  logic [SPR_ORG_W-1:0]           i_attr_sy,
  input  logic [SPR_SIZE_W-1:0]          i_attr_w,
  input  logic [SPR_SIZE_W-1:0]          i_attr_h,
  input  logic                           i_attr_en,
  input  logic                           i_attr_flip,
  output logic [ADDR_W-1:0]              o_rom_addr,
  input  logic [IDX_W-1:0]               i_rom_q,
  output logic [IDX_W-1:0]               o_pix_idx,
  output logic                           o_pix_valid,
  output logic                           o_blank_out
);

  localparam int AW2 = ADDR_W + 2;
  localparam logic [AW2-1:0] LP_SHEET_W = AW2'(SHEET_W);
  localparam logic [AW2-1:0] LP_SHEET_H = AW2'(SHEET_H);

  sprite_attr_t r_shadow [NUM_SPRITES];
  sprite_attr_t r_active [NUM_SPRITES];
  sprite_attr_t w_new_attr;

  logic [NUM_SPRITES-1:0] w_hit;
  logic [SPR_SIZE_W-1:0]  w_tx [NUM_SPRITES];
  logic [SPR_SIZE_W-1:0]  w_ty [NUM_SPRITES];

  logic                  w_win_hit;
  logic [SPR_SIZE_W-1:0] w_win_tx, w_win_ty;
  logic [SPR_ORG_W-1:0]  w_win_sx, w_win_sy;

  logic                  r_s1_hit, r_s1_blank;
  logic [SPR_SIZE_W-1:0] r_s1_tx, r_s1_ty;
  logic [SPR_ORG_W-1:0]  r_s1_sx, r_s1_sy;

  logic [SPR_ORG_W:0]    w_col, w_row;
  logic [AW2-1:0]        w_col_x, w_row_x, w_addr_full;
  logic                  w_s2_hit;

  logic [ADDR_W-1:0]     r_rom_addr;
  logic                  r_s2_hit, r_s2_blank;
  logic [ROM_LAT-1:0]    r_dly_hit, r_dly_blank;

  logic                  w_pix_valid;
  logic [IDX_W-1:0]      r_pix_idx;
  logic                  r_pix_valid, r_blank_out;

  assign w_new_attr = '{x: i_attr_x, y: i_attr_y, sx: i_attr_sx, sy: i_attr_sy,
                        w: i_attr_w, h: i_attr_h, en: i_attr_en, flip: i_attr_flip};

  // Attribute banks: writes go to shadow; frame_start publishes shadow, with write-through of a same-cycle write.
  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (i_attr_we) r_shadow[i_attr_sel] <= w_new_attr;
      if (i_frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++) r_active[i] <= r_shadow[i];
        if (i_attr_we) r_active[i_attr_sel] <= w_new_attr;
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    sprite_hit_test #(.SCALE_LOG2(SCALE_LOG2)) u_hit (
      .i_attr   (r_active[g]),
      .i_draw_x (i_draw_x),
      .i_draw_y (i_draw_y),
      .o_hit    (w_hit[g]),
      .o_tx     (w_tx[g]),
      .o_ty     (w_ty[g])
    );
  end

  // Priority select: scan from lowest priority upward so slot 0 overrides everything.
  always_comb begin
    w_win_hit = 1'b0;
    w_win_tx  = '0;
    w_win_ty  = '0;
    w_win_sx  = '0;
    w_win_sy  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win_hit = 1'b1;
        w_win_tx  = w_tx[i];
        w_win_ty  = w_ty[i];
        w_win_sx  = r_active[i].sx;
        w_win_sy  = r_active[i].sy;
      end
    end
  end

  // Stage 1: register the winning slot's texel and sheet origin.
  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1_hit   <= 1'b0;
      r_s1_blank <= 1'b0;
      r_s1_tx    <= '0;
      r_s1_ty    <= '0;
      r_s1_sx    <= '0;
      r_s1_sy    <= '0;
    end else begin
      r_s1_hit   <= w_win_hit;
      r_s1_blank <= i_blank;
      r_s1_tx    <= w_win_tx;
      r_s1_ty    <= w_win_ty;
      r_s1_sx    <= w_win_sx;
      r_s1_sy    <= w_win_sy;
    end
  end

  assign w_col       = {1'b0, r_s1_sx} + {3'b000, r_s1_tx};
  assign w_row       = {1'b0, r_s1_sy} + {3'b000, r_s1_ty};
  assign w_col_x     = AW2'(w_col);
  assign w_row_x     = AW2'(w_row);
  assign w_addr_full = w_row_x * LP_SHEET_W + w_col_x;
  // Texels past the sheet edge are misses; the top-bit guard only matters if ADDR_W is undersized.
  assign w_s2_hit    = r_s1_hit & (w_col_x < LP_SHEET_W) & (w_row_x < LP_SHEET_H)
                     & (w_addr_full[AW2-1:ADDR_W] == 2'b00);

  // Stage 2: registered ROM address, zero on a miss.
  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rom_addr <= '0;
      r_s2_hit   <= 1'b0;
      r_s2_blank <= 1'b0;
    end else begin
      r_rom_addr <= w_s2_hit ? w_addr_full[ADDR_W-1:0] : '0;
      r_s2_hit   <= w_s2_hit;
      r_s2_blank <= r_s1_blank;
    end
  end

  // Delay hit and blank by the ROM latency so they meet rom_q.
  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dly_hit   <= '0;
      r_dly_blank <= '0;
    end else begin
      r_dly_hit[0]   <= r_s2_hit;
      r_dly_blank[0] <= r_s2_blank;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_dly_hit[i]   <= r_dly_hit[i-1];
        r_dly_blank[i] <= r_dly_blank[i-1];
      end
    end
  end

  // A transparent winner texel is reported as a miss; lower slots do not show through.
  assign w_pix_valid = r_dly_hit[ROM_LAT-1] & r_dly_blank[ROM_LAT-1] & (i_rom_q != TRANSPARENT_IDX);

  // Output register.
  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pix_idx   <= '0;
      r_pix_valid <= 1'b0;
      r_blank_out <= 1'b0;
    end else begin
      r_pix_idx   <= w_pix_valid ? i_rom_q : '0;
      r_pix_valid <= w_pix_valid;
      r_blank_out <= r_dly_blank[ROM_LAT-1];
    end
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_pix_idx   = r_pix_idx;
  assign o_pix_valid = r_pix_valid;
  assign o_blank_out = r_blank_out;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Scoreboard bench for sprite_layer_compositor with a behavioural sprite model.
module tb_sprite_layer_compositor;
  import sprite_pkg::*;

  localparam int SHEET_W = 360;
  localparam int SHEET_H = 264;
  localparam int ROM_LAT = 1;
  localparam int SCALE   = 2;
  localparam int NSPR    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  i_draw_x = '0, i_draw_y = '0;
  logic        i_blank = 1'b0, i_frame_start = 1'b0, i_attr_we = 1'b0;
  logic [1:0]  i_attr_sel = '0;
  logic signed [10:0] i_attr_x = '0, i_attr_y = '0;
  logic [8:0]  i_attr_sx = '0, i_attr_sy = '0;
  logic [6:0]  i_attr_w = '0, i_attr_h = '0;
  logic        i_attr_en = 1'b0, i_attr_flip = 1'b0;
  logic [16:0] o_rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  o_pix_idx;
  logic        o_pix_valid, o_blank_out;

  sprite_layer_compositor dut (
    .i_vga_clk(clk), .i_reset(rst),
    .i_draw_x(i_draw_x), .i_draw_y(i_draw_y), .i_blank(i_blank),
    .i_frame_start(i_frame_start), .i_attr_we(i_attr_we), .i_attr_sel(i_attr_sel),
    .i_attr_x(i_attr_x), .i_attr_y(i_attr_y), .i_attr_sx(i_attr_sx), .i_attr_sy(i_attr_sy),
    .i_attr_w(i_attr_w), .i_attr_h(i_attr_h), .i_attr_en(i_attr_en), .i_attr_flip(i_attr_flip),
    .o_rom_addr(o_rom_addr), .i_rom_q(rom_q),
    .o_pix_idx(o_pix_idx), .o_pix_valid(o_pix_valid), .o_blank_out(o_blank_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External sheet ROM with ROM_LAT cycles of latency.
  logic [3:0] rom_mem [0:SHEET_W*SHEET_H-1];
  logic [3:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= (int'(o_rom_addr) < SHEET_W*SHEET_H) ? rom_mem[int'(o_rom_addr)] : 4'd0;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  typedef struct { int due; logic [16:0] addr; } addr_e_t;
  typedef struct { int due; logic v; logic [3:0] idx; logic bl; } pix_e_t;
  addr_e_t addr_q[$];
  pix_e_t  pix_q[$];

  int total = 0;
  int bad   = 0;

  sprite_attr_t m_shd [NSPR];
  sprite_attr_t m_act [NSPR];
  sprite_attr_t z_attr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int s11(input logic [10:0] v);
    return v[10] ? int'(v[9:0]) - 1024 : int'(v[9:0]);
  endfunction

  // Reference: first enabled slot covering the pixel wins; its texel may still be off-sheet or transparent.
  function automatic void model(input int px, input int py, input logic bl,
                                output logic [16:0] addr, output logic v, output logic [3:0] idx);
    logic ok;
    logic [3:0] texel;
    int lx, ly, tx, ty, col, row, a;
    addr = '0; v = 1'b0; idx = '0; ok = 1'b0; a = 0;
    for (int s = 0; s < NSPR; s++) begin
      if (m_act[s].en) begin
        lx = px - s11(m_act[s].x);
        ly = py - s11(m_act[s].y);
        if (lx >= 0 && lx < int'(m_act[s].w) * SCALE && ly >= 0 && ly < int'(m_act[s].h) * SCALE) begin
          tx = lx / SCALE;
          if (m_act[s].flip) tx = int'(m_act[s].w) - 1 - tx;
          ty = ly / SCALE;
          col = int'(m_act[s].sx) + tx;
          row = int'(m_act[s].sy) + ty;
          if (col < SHEET_W && row < SHEET_H) begin
            ok = 1'b1;
            a = row * SHEET_W + col;
          end
          break;
        end
      end
    end
    if (ok) begin
      addr  = 17'(a);
      texel = rom_mem[a];
      v     = bl && (texel != 4'd0);
      idx   = v ? texel : 4'd0;
    end
  endfunction

  task automatic step(input int px, input int py, input logic bl, input logic we,
                      input int sel, input sprite_attr_t a, input logic fs);
    addr_e_t ea;
    pix_e_t  ep;
    logic [16:0] ad;
    logic v;
    logic [3:0] ix;
    @(negedge clk);
    i_draw_x = 10'(px); i_draw_y = 10'(py); i_blank = bl;
    i_attr_we = we; i_frame_start = fs; i_attr_sel = 2'(sel);
    i_attr_x = a.x; i_attr_y = a.y; i_attr_sx = a.sx; i_attr_sy = a.sy;
    i_attr_w = a.w; i_attr_h = a.h; i_attr_en = a.en; i_attr_flip = a.flip;
    model(px, py, bl, ad, v, ix);
    ea.due = cyc + 2;           ea.addr = ad;
    ep.due = cyc + ROM_LAT + 3; ep.v = v; ep.idx = ix; ep.bl = bl;
    addr_q.push_back(ea);
    pix_q.push_back(ep);
    if (we) m_shd[sel] = a;
    if (fs) for (int i = 0; i < NSPR; i++) m_act[i] = m_shd[i];
  endtask

  task automatic pix(input int px, input int py, input logic bl);
    step(px, py, bl, 1'b0, 0, z_attr, 1'b0);
  endtask

  function automatic sprite_attr_t mk(input int x, input int y, input int sx, input int sy,
                                      input int w, input int h, input logic en, input logic fl);
    sprite_attr_t a;
    a.x = 11'(x); a.y = 11'(y); a.sx = 9'(sx); a.sy = 9'(sy);
    a.w = 7'(w); a.h = 7'(h); a.en = en; a.flip = fl;
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_attr_we = 1'b0; i_frame_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(o_pix_valid), 32'd0);
    chk("rst_idx",   32'(o_pix_idx),   32'd0);
    chk("rst_addr",  32'(o_rom_addr),  32'd0);
    chk("rst_blank", 32'(o_blank_out), 32'd0);
    addr_q.delete();
    pix_q.delete();
    for (int i = 0; i < NSPR; i++) begin m_shd[i] = '0; m_act[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops whatever is due this cycle and compares against the DUT.
  initial begin
    addr_e_t ea;
    pix_e_t  ep;
    forever begin
      @(posedge clk);
      #1;
      while (addr_q.size() > 0 && addr_q[0].due == cyc) begin
        ea = addr_q.pop_front();
        chk("rom_addr", 32'(o_rom_addr), 32'(ea.addr));
      end
      while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        ep = pix_q.pop_front();
        chk("pix_valid", 32'(o_pix_valid), 32'(ep.v));
        chk("pix_idx",   32'(o_pix_idx),   32'(ep.idx));
        chk("blank_out", 32'(o_blank_out), 32'(ep.bl));
      end
    end
  end

  initial begin
    sprite_attr_t a0, a1, a2, a3, ar;
    int px, py, s, waited;

    for (int i = 0; i < SHEET_W*SHEET_H; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    rom_mem[20*SHEET_W + 10] = 4'd9;
    rom_mem[60*SHEET_W + 67] = 4'd0;
    rom_mem[60*SHEET_W + 66] = 4'd5;
    rom_mem[5*SHEET_W + 5]   = 4'd7;
    for (int i = 0; i < NSPR; i++) begin m_shd[i] = '0; m_act[i] = '0; end

    repeat (3) @(negedge clk);
    chk("init_valid", 32'(o_pix_valid), 32'd0);
    chk("init_addr",  32'(o_rom_addr),  32'd0);
    rst = 1'b0;

    // Basic sprite: origin, far edge, bottom edge.
    a0 = mk(275, 360, 10, 20, 18, 32, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b1, 0, a0, 1'b1);
    pix(275, 360, 1'b1);
    pix(311, 360, 1'b1);
    pix(310, 360, 1'b1);
    pix(275, 423, 1'b1);
    pix(275, 424, 1'b1);
    pix(274, 360, 1'b1);

    // Overlap: slot0 over slot2, then slot0 disabled via write-through.
    a2 = mk(290, 365, 100, 100, 20, 20, 1'b1, 1'b0);
    step(300, 370, 1'b1, 1'b1, 2, a2, 1'b1);
    pix(300, 370, 1'b1);
    a0.en = 1'b0;
    step(300, 370, 1'b1, 1'b1, 0, a0, 1'b1);
    pix(300, 370, 1'b1);

    // Shadow write without frame_start is invisible until the swap.
    a2 = mk(0, 0, 100, 100, 20, 20, 1'b1, 1'b0);
    step(300, 370, 1'b1, 1'b1, 2, a2, 1'b0);
    pix(300, 370, 1'b1);
    step(301, 371, 1'b1, 1'b0, 0, z_attr, 1'b1);
    pix(300, 370, 1'b1);
    pix(10, 10, 1'b1);

    // Flip and transparent winner over an opaque lower-priority slot.
    a1 = mk(100, 100, 50, 60, 18, 4, 1'b1, 1'b1);
    a3 = mk(90, 90, 0, 0, 30, 30, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b1, 1, a1, 1'b0);
    step(0, 0, 1'b1, 1'b1, 3, a3, 1'b1);
    pix(100, 100, 1'b1);
    pix(102, 100, 1'b1);
    pix(135, 100, 1'b1);
    pix(136, 100, 1'b1);

    // Negative x clipping and sheet overrun past texel 9.
    a0 = mk(-10, 0, 350, 0, 18, 4, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b1, 0, a0, 1'b1);
    for (int x = 0; x < 30; x++) pix(x, 0, 1'b1);
    for (int x = 0; x < 6; x++)  pix(x, 1, 1'b0);
    pix(12, 12, 1'b0);

    // Reset with pixels in flight, then rebuild and check alignment after release.
    pix(5, 2, 1'b1);
    pix(6, 2, 1'b1);
    do_reset();
    a0 = mk(275, 360, 10, 20, 18, 32, 1'b1, 1'b0);
    step(275, 360, 1'b1, 1'b1, 0, a0, 1'b1);
    pix(275, 360, 1'b1);
    pix(276, 362, 1'b1);
    pix(290, 380, 1'b1);

    // Randomised frames.
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) begin
        ar = mk(int'($urandom_range(0, 750)) - 50, int'($urandom_range(0, 550)) - 50,
                int'($urandom_range(0, 400)), int'($urandom_range(0, 300)),
                int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
        step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1,
             1'b1, int'($urandom_range(0, 3)), ar, 1'($urandom_range(0, 1)));
      end else begin
        s  = int'($urandom_range(0, 3));
        px = s11(m_shd[s].x) + int'($urandom_range(0, 2*int'(m_shd[s].w) + 8)) - 4;
        py = s11(m_shd[s].y) + int'($urandom_range(0, 2*int'(m_shd[s].h) + 8)) - 4;
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
        step(px, py, $urandom_range(0, 9) != 0, 1'b0, 0, z_attr, n % 97 == 0);
      end
    end

    @(negedge clk);
    i_attr_we = 1'b0; i_frame_start = 1'b0;
    waited = 0;
    while ((addr_q.size() > 0 || pix_q.size() > 0) && waited < 30) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("drain", 32'(addr_q.size() + pix_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
